// File: rtl/ssriscv_muldiv.sv
// ---------------------------------------------------------------------------
// ssriscv_muldiv
//   Iterative RV32M multiply/divide unit. One request is accepted at a time.
//   The result is held until the writeback stage consumes it.
//
//   Timing (accept edge = E0):
//     E1       load edge. A divide by zero or a signed overflow goes straight
//              to DONE here; any other request loads the accumulator.
//     E2..E33  iterations 0..31. E33 enters DONE with the final result.
//
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     in_valid   request present
//     in_ready   unit can accept a request: IDLE and no flush
//     funct3     0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//     rs1_data   operand 1 (dividend / multiplicand side)
//     rs2_data   operand 2 (divisor / multiplier side)
//     rd_in      destination register tag
//     flush      abort any in-flight operation, discard any result
//     out_valid  result present
//     out_ready  writeback consumer accepts the result
//     out_rd     destination tag of the result (0 when out_valid=0)
//     out_data   result value (0 when out_valid=0)
// ---------------------------------------------------------------------------
module ssriscv_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement negate when neg is set.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // 64-bit flavour, used to fix up the sign of a full product.
  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    logic [63:0] r;
    if (neg) begin
      r = ~v + 64'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Registered state
  state_t            state_r, state_next;
  logic              prep_r, prep_next;           // in the load edge of CALC
  logic [4:0]        cnt_r, cnt_next;             // iteration counter
  logic [2:0]        op_r, op_next;
  logic [4:0]        rd_r, rd_next;
  logic [XLEN-1:0]   a_r, a_next;                 // |rs1| (or rs1 when unsigned)
  logic [XLEN-1:0]   b_r, b_next;                 // |rs2| (or rs2 when unsigned)
  logic              neg_r, neg_next;             // final result must be negated
  logic              byp_r, byp_next;             // divide by zero / overflow
  logic [XLEN-1:0]   byp_data_r, byp_data_next;   // result for the bypass cases
  logic [2*XLEN-1:0] acc_r, acc_next;             // {hi, lo} working accumulator
  logic              out_valid_r, out_valid_next;
  logic [4:0]        out_rd_r, out_rd_next;
  logic [XLEN-1:0]   out_data_r, out_data_next;

  // Request decode (only meaningful on the accept edge)
  logic            sgn1_s, sgn2_s;
  logic            neg1_s, neg2_s;
  logic            is_div_s;
  logic            res_neg_s;
  logic            div_zero_s, div_ovf_s;
  logic [XLEN-1:0] byp_val_s;

  // Iteration datapath
  logic [32:0]       mul_sum_s;
  logic [2*XLEN-1:0] mul_step_s;
  logic [32:0]       div_trial_s;
  logic [2*XLEN-1:0] div_step_s;
  logic [2*XLEN-1:0] iter_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   final_s;

  // Decides which operands are signed for the incoming funct3.
  always_comb begin
    sgn1_s = 1'b0;
    sgn2_s = 1'b0;
    case (funct3)
      3'd1:    begin sgn1_s = 1'b1; sgn2_s = 1'b1; end  // MULH
      3'd2:    begin sgn1_s = 1'b1; sgn2_s = 1'b0; end  // MULHSU
      3'd4:    begin sgn1_s = 1'b1; sgn2_s = 1'b1; end  // DIV
      3'd6:    begin sgn1_s = 1'b1; sgn2_s = 1'b1; end  // REM
      default: begin sgn1_s = 1'b0; sgn2_s = 1'b0; end  // MUL low half is sign-agnostic
    endcase
  end

  assign neg1_s   = sgn1_s & rs1_data[31];
  assign neg2_s   = sgn2_s & rs2_data[31];
  assign is_div_s = funct3[2];

  // Remainder follows the dividend; quotient and product follow the xor.
  assign res_neg_s = (funct3[2] && funct3[1]) ? neg1_s : (neg1_s ^ neg2_s);

  assign div_zero_s = is_div_s && (rs2_data == 32'd0);
  assign div_ovf_s  = is_div_s && !funct3[0] &&
                      (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);

  // Bypass result: funct3[1] selects REM/REMU over DIV/DIVU.
  always_comb begin
    byp_val_s = 32'd0;
    if (div_zero_s) begin
      byp_val_s = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
    end else if (div_ovf_s) begin
      byp_val_s = funct3[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      byp_val_s = 32'd0;
    end
  end

  // Shift-add: add the multiplicand into the high half when the low bit of
  // the multiplier is set, then shift the whole accumulator right by one.
  assign mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, b_r} : 33'd0);
  assign mul_step_s = {mul_sum_s, acc_r[31:1]};

  // Restoring division: shift {rem, quot} left, try subtracting the divisor
  // from the 33-bit partial remainder; bit 32 of the trial is the borrow.
  assign div_trial_s = acc_r[63:31] - {1'b0, b_r};
  assign div_step_s  = div_trial_s[32] ? {acc_r[62:0], 1'b0}
                                       : {div_trial_s[31:0], acc_r[30:0], 1'b1};

  assign iter_s = op_r[2] ? div_step_s : mul_step_s;
  assign prod_s = cond_neg64(iter_s, neg_r);

  // Picks the architectural result out of the last iteration's accumulator.
  always_comb begin
    final_s = 32'd0;
    if (op_r[2]) begin
      if (op_r[1]) begin
        final_s = cond_neg32(iter_s[63:32], neg_r);   // remainder
      end else begin
        final_s = cond_neg32(iter_s[31:0], neg_r);    // quotient
      end
    end else begin
      if (op_r == 3'd0) begin
        final_s = prod_s[31:0];
      end else begin
        final_s = prod_s[63:32];
      end
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_next     = state_r;
    prep_next      = prep_r;
    cnt_next       = cnt_r;
    op_next        = op_r;
    rd_next        = rd_r;
    a_next         = a_r;
    b_next         = b_r;
    neg_next       = neg_r;
    byp_next       = byp_r;
    byp_data_next  = byp_data_r;
    acc_next       = acc_r;
    out_valid_next = out_valid_r;
    out_rd_next    = out_rd_r;
    out_data_next  = out_data_r;

    if (flush) begin
      // flush wins over in_valid and out_ready; any result is dropped
      state_next     = IDLE;
      prep_next      = 1'b0;
      cnt_next       = 5'd0;
      out_valid_next = 1'b0;
      out_rd_next    = 5'd0;
      out_data_next  = 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_next    = CALC;
            prep_next     = 1'b1;
            cnt_next      = 5'd0;
            op_next       = funct3;
            rd_next       = rd_in;
            a_next        = cond_neg32(rs1_data, neg1_s);
            b_next        = cond_neg32(rs2_data, neg2_s);
            neg_next      = res_neg_s;
            byp_next      = div_zero_s | div_ovf_s;
            byp_data_next = byp_val_s;
            acc_next      = 64'd0;
          end else begin
            state_next = IDLE;
          end
        end

        CALC: begin
          if (prep_r) begin
            prep_next = 1'b0;
            if (byp_r) begin
              state_next     = DONE;
              out_valid_next = 1'b1;
              out_rd_next    = rd_r;
              out_data_next  = byp_data_r;
            end else begin
              state_next = CALC;
              acc_next   = {32'd0, a_r};
            end
          end else begin
            acc_next = iter_s;
            cnt_next = cnt_r + 5'd1;
            if (cnt_r == 5'd31) begin
              state_next     = DONE;
              out_valid_next = 1'b1;
              out_rd_next    = rd_r;
              out_data_next  = final_s;
            end else begin
              state_next = CALC;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
            out_rd_next    = 5'd0;
            out_data_next  = 32'd0;
          end else begin
            state_next = DONE;
          end
        end

        default: begin
          state_next     = IDLE;
          prep_next      = 1'b0;
          cnt_next       = 5'd0;
          out_valid_next = 1'b0;
          out_rd_next    = 5'd0;
          out_data_next  = 32'd0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prep_r      <= 1'b0;
      cnt_r       <= 5'd0;
      op_r        <= 3'd0;
      rd_r        <= 5'd0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      neg_r       <= 1'b0;
      byp_r       <= 1'b0;
      byp_data_r  <= 32'd0;
      acc_r       <= 64'd0;
      out_valid_r <= 1'b0;
      out_rd_r    <= 5'd0;
      out_data_r  <= 32'd0;
    end else begin
      prep_r      <= prep_next;
      cnt_r       <= cnt_next;
      op_r        <= op_next;
      rd_r        <= rd_next;
      a_r         <= a_next;
      b_r         <= b_next;
      neg_r       <= neg_next;
      byp_r       <= byp_next;
      byp_data_r  <= byp_data_next;
      acc_r       <= acc_next;
      out_valid_r <= out_valid_next;
      out_rd_r    <= out_rd_next;
      out_data_r  <= out_data_next;
    end
  end

  assign in_ready  = (state_r == IDLE) && !flush;
  assign out_valid = out_valid_r;
  assign out_rd    = out_rd_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_ssriscv_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ssriscv_muldiv
//   Directed bench for ssriscv_muldiv. A transaction-level reference model
//   (plain arithmetic plus an edges-until-result countdown) runs alongside
//   the DUT. A compare process checks every output 1 time unit after each
//   rising edge. Directed vectors carry hand-computed results and latencies.
// ---------------------------------------------------------------------------
module tb_ssriscv_muldiv;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3    = 3'd0;
  logic [31:0] rs1_data  = 32'd0;
  logic [31:0] rs2_data  = 32'd0;
  logic [4:0]  rd_in     = 5'd0;
  logic        flush     = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  ssriscv_muldiv #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_data  (out_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural RV32M result.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Edges from accept until out_valid is seen.
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && (b == 32'd0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Transaction-level model: busy with a countdown, or holding a result.
  logic        m_busy  = 1'b0;
  logic        m_valid = 1'b0;
  int          m_left  = 0;
  logic [4:0]  m_rd    = 5'd0;
  logic [31:0] m_data  = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_rd    <= 5'd0;
      m_data  <= 32'd0;
    end else if (flush) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
      end
    end else if (in_valid) begin
      m_busy <= 1'b1;
      m_left <= ref_latency(funct3, rs1_data, rs2_data);
      m_rd   <= rd_in;
      m_data <= ref_result(funct3, rs1_data, rs2_data);
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
    check("cyc_in_ready", 32'(in_ready), 32'(!m_busy && !m_valid && !flush));
    check("cyc_out_rd", 32'(out_rd), m_valid ? 32'(m_rd) : 32'd0);
    check("cyc_out_data", out_data, m_valid ? m_data : 32'd0);
  end

  // Present a request and return at the negedge after the accept edge,
  // scrambling the operand inputs so late changes would show up.
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    funct3   = ~f;
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_in    = ~rd;
  endtask

  // Count edges after accept until out_valid, bounded.
  task automatic wait_result(output int lat, output logic seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      #2;
      if (out_valid) seen = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic seen;
    send(f, a, b, rd);
    wait_result(lat, seen);
    check({name, "_seen"}, 32'(seen), 32'd1);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_data"}, out_data, exp);
    check({name, "_rd"}, 32'(out_rd), 32'(rd));
    @(posedge clk);
    #2;
    check({name, "_consumed"}, 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int   lat;
    logic seen;
    int   nvalid;

    // Hand-computed vectors
    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33}); // MUL 7*-3
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33}); // MULH
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,          5'd7,  32'hFFFF_FFFD, 33}); // DIV -7/2
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,          5'd8,  32'hFFFF_FFFF, 33}); // REM -7/2
    vecs.push_back('{3'd5, 32'hFFFF_FFFE, 32'd2,          5'd9,  32'h7FFF_FFFF, 33}); // DIVU
    vecs.push_back('{3'd5, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF, 1});  // DIVU /0
    vecs.push_back('{3'd7, 32'd5,          32'd0,          5'd11, 32'd5,         1});  // REMU /0
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1});  // DIV ovf
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1});  // REM ovf
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,          5'd0,  32'hFFFF_FFFF, 33}); // MULHSU, rd 0
    vecs.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 33}); // DIV 7/-2
    vecs.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE, 5'd15, 32'd1,         33}); // REM 7/-2
    vecs.push_back('{3'd5, 32'd100,        32'd7,          5'd16, 32'd14,        33}); // DIVU
    vecs.push_back('{3'd7, 32'd100,        32'd7,          5'd17, 32'd2,         33}); // REMU
    vecs.push_back('{3'd0, 32'h1234_5678, 32'd9,          5'd31, 32'hA3D7_0A38, 33}); // MUL

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, vecs[i].lat);
    end

    // Backpressure: hold the result for 10 cycles
    @(negedge clk);
    out_ready = 1'b0;
    send(3'd0, 32'd1000, 32'd3000, 5'd9);
    wait_result(lat, seen);
    check("bp_seen", 32'(seen), 32'd1);
    check("bp_lat", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", out_data, 32'h002D_C6C0);
      check("bp_hold_rd", 32'(out_rd), 32'd9);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    check("bp_consumed", 32'(out_valid), 32'd0);
    check("bp_no_same_cycle_ready", 32'(in_ready), 32'd1);

    // Abort by flush during iteration 10
    send(3'd0, 32'd123, 32'd456, 5'd3);
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #2;
    check("flush_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle_ready", 32'(in_ready), 32'd1);
    nvalid = 0;
    repeat (40) begin
      @(posedge clk);
      #2;
      if (out_valid) nvalid++;
    end
    check("flush_no_result", 32'(nvalid), 32'd0);

    // Abort by reset during iteration 20
    send(3'd0, 32'd123, 32'd456, 5'd4);
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_release_ready", 32'(in_ready), 32'd1);
    nvalid = 0;
    repeat (40) begin
      @(posedge clk);
      #2;
      if (out_valid) nvalid++;
    end
    check("arst_no_result", 32'(nvalid), 32'd0);

    run_op("post_abort_mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'hFFFF_FFFE, 33);

    repeat (2) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ssriscv_muldiv.md
SSRISCV_MULDIV -- requirements
Module: ssriscv_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width; only 32 is supported.
REQ-002 SHALL have port `clk`, input, 1: clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst_n`, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port `in_valid`, input, 1: request present.
REQ-005 SHALL have port `in_ready`, output, 1: unit can accept a request.
REQ-006 SHALL have port `funct3`, input, 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have ports `rs1_data` and `rs2_data`, input, 32 each: operands as read from the register file.
REQ-008 SHALL have port `rd_in`, input, 5: destination register tag.
REQ-009 SHALL have port `flush`, input, 1: abort any in-flight operation.
REQ-010 SHALL have port `out_valid`, output, 1: result present.
REQ-011 SHALL have port `out_ready`, input, 1: writeback consumer accepts.
REQ-012 SHALL have ports `out_rd` (output, 5) and `out_data` (output, 32): destination tag and result, driving the register-file write port.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; in_ready = (state==IDLE) && !flush.
REQ-014 SHALL accept on a rising edge with in_valid && in_ready: latch funct3, rd_in, operand magnitudes and result sign; go to CALC with iteration counter 0.
REQ-015 CALC SHALL perform one iteration per edge: shift-add for multiply, restoring shift-subtract for divide, on 32-bit unsigned magnitudes with a 64-bit accumulator.
REQ-016 CALC SHALL move to DONE on the edge completing iteration 31, so out_valid rises exactly 33 edges after the accept edge.
REQ-017 Signedness SHALL be: MULH and DIV/REM both signed; MULHSU rs1 signed, rs2 unsigned; MULHU, DIVU and REMU unsigned.
REQ-018 Results SHALL be: MUL low 32 bits of the product; MULH* high 32 bits of the 64-bit product; quotient truncated toward zero; remainder takes the sign of the dividend.
REQ-019 Divide by zero SHALL bypass CALC and enter DONE on the edge after accept: DIV/DIVU result 0xFFFFFFFF; REM/REMU result rs1.
REQ-020 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF) SHALL bypass CALC the same way: DIV result 0x80000000; REM result 0.
REQ-021 DONE SHALL hold out_valid=1 with out_rd/out_data stable until out_valid && out_ready, then return to IDLE on that edge.
REQ-022 A new request SHALL NOT be accepted in the cycle a result is consumed; the earliest next accept is the following cycle.
REQ-023 flush SHALL force IDLE on the next edge from any state, discarding any result; out_valid SHALL be 0 from that edge; flush overrides in_valid and out_ready in the same cycle.
REQ-024 out_data and out_rd SHALL be 0 whenever out_valid=0.
REQ-025 rd_in=0 SHALL be processed normally and delivered with out_rd=0; discarding the write is the consumer's job.
REQ-026 Inputs SHALL be sampled only at the accept edge; later changes on rs1_data, rs2_data or funct3 SHALL NOT affect the result.

Reset
REQ-027 rst_n low SHALL immediately, asynchronously force state IDLE, counter 0, accumulators 0, out_valid 0, out_rd 0, out_data 0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL lose the operation with no output.
REQ-029 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-030 Check MUL 7×(-3) and MULH 0x80000000×0x80000000, with out_ready held 1: MUL gives out_data=0xFFFFFFEB and MULH gives 0x40000000, each with out_valid exactly 33 edges after accept.
REQ-031 Check DIV -7/2, REM -7/2 and DIVU 0xFFFFFFFE/2: results are 0xFFFFFFFD, 0xFFFFFFFF and 0x7FFFFFFF respectively.
REQ-032 Check DIVU 5/0, REMU 5/0 and DIV 0x80000000/-1: results are 0xFFFFFFFF, 5 and 0x80000000, each with out_valid 1 edge after accept.
REQ-033 Check backpressure: hold out_ready=0 for 10 cycles in DONE; out_valid, out_rd and out_data stay stable and in_ready stays 0; one result is delivered when out_ready rises.
REQ-034 Check abort: assert flush at CALC iteration 10, then at iteration 20 assert rst_n low; each gives IDLE next edge (reset immediately), out_valid never rises, and a following MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE.
